note_buzzer: RTL and testbench

Downstream stage of the song memory. Paces playback by emitting a one-cycle `beat` pulse that advances the song counter, latches the returned note index once per beat, and drives the piezo speaker with a square wave at that note's pitch. A short silent gap at the end of every beat articulates repeated notes. Honours the shared play/pause/stop state.

---
 rtl/piano_pkg.sv | 20 ++
 rtl/note_buzzer_tone_divider.sv | 27 ++
 rtl/note_buzzer.sv | 65 ++++++
 tb/tb_note_buzzer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: play-state encodings, note frequency table (milli-Hz) and half-period helper
package piano_pkg;
  localparam logic [1:0] sstop  = 2'b00;
  localparam logic [1:0] splay  = 2'b01;
  localparam logic [1:0] spause = 2'b10;
  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE} fsm_t;
  // index 0 is silence; low octave is the middle octave halved and truncated to 0.01 Hz
  localparam int unsigned NOTE_MHZ [22] = '{
    0,
    130810, 146830, 164810, 174610, 196000, 220000, 246940,
    261630, 293660, 329630, 349230, 392000, 440000, 493880,
    523260, 587320, 659260, 698460, 784000, 880000, 987760
  };
  function automatic logic [19:0] half_period(input longint unsigned clk_hz, input logic [4:0] n);
    longint unsigned f;
    f = 0;
    if (n < 5'd22) f = 64'(NOTE_MHZ[n]);
    return (f == 0) ? 20'd0 : 20'((clk_hz * 1000 + f) / (2 * f));
  endfunction
endpackage

// File: rtl/note_buzzer_tone_divider.sv
// tone_divider: square wave toggling every half_period cycles; en low holds, restart clears
module tone_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [19:0] half_period,
  input  logic        restart,
  output logic        sq
);
  logic [19:0] cnt_q, cnt_d;
  logic        sq_q, sq_d;
  logic        wrap;
  assign wrap = cnt_q == half_period - 20'd1;
  assign sq = sq_q;
  always_comb begin
    cnt_d = restart ? 20'd0 : !en ? cnt_q : wrap ? 20'd0 : cnt_q + 20'd1;
    sq_d  = restart ? 1'b0 : (en && wrap) ? ~sq_q : sq_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
endmodule

// File: rtl/note_buzzer.sv
// note_buzzer: paces song playback with a beat pulse and drives the piezo at the latched note pitch
module note_buzzer
  import piano_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int LOAD_AT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  input  logic [4:0] note,
  output logic       beat,
  output logic       speaker,
  output logic [4:0] cur_note,
  output logic       sounding
);
  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] LOAD = CW'(LOAD_AT);
  localparam logic [CW-1:0] WEND = CW'(BEAT_CYCLES - GAP_CYCLES);
  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [4:0]    cur_note_q, cur_note_d;
  logic          beat_q, beat_d;
  logic          play, sq;
  logic [19:0]   hp_tab [32];
  for (genvar i = 0; i < 32; i++) begin : g_hp
    localparam logic [19:0] HP = half_period(64'(CLK_HZ), 5'(i));
    assign hp_tab[i] = HP;
  end
  assign play     = fsm_q == ST_PLAY;
  assign sounding = play && cur_note_q != '0 && beat_cnt_q > LOAD && beat_cnt_q < WEND;
  assign speaker  = sq && sounding;
  assign beat     = beat_q;
  assign cur_note = cur_note_q;
  always_comb begin
    fsm_d      = state == splay ? ST_PLAY : state == spause ? ST_PAUSE : ST_STOP;
    beat_cnt_d = fsm_q == ST_STOP ? '0 : !play ? beat_cnt_q : beat_cnt_q == LAST ? '0 : beat_cnt_q + CW'(1);
    cur_note_d = fsm_q == ST_STOP ? '0 : (play && beat_cnt_q == LOAD) ? (note > 5'd21 ? 5'd0 : note) : cur_note_q;
    beat_d     = fsm_d == ST_PLAY && beat_cnt_d == LAST;
  end
  // pause leaves the divider frozen (en low, no restart); play outside the window clears it
  tone_divider u_tone (
    .clk         (clk),
    .reset       (reset),
    .en          (sounding),
    .half_period (hp_tab[cur_note_q]),
    .restart     (fsm_q == ST_STOP || (play && !sounding)),
    .sq          (sq)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fsm_q      <= ST_STOP;
      beat_cnt_q <= '0;
      cur_note_q <= '0;
      beat_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      beat_cnt_q <= beat_cnt_d;
      cur_note_q <= cur_note_d;
      beat_q     <= beat_d;
    end
endmodule

// File: tb/tb_note_buzzer.sv
// tb_note_buzzer: directed checks of beat pacing, note latch, tone, pause/stop and async reset
module tb_note_buzzer;
  import piano_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state = sstop;
  logic [4:0] note = 5'd0;
  logic       beat, speaker, sounding;
  logic [4:0] cur_note;
  int n_chk = 0;
  int n_fail = 0;

  note_buzzer #(
    .CLK_HZ(1_000_000), .BEAT_CYCLES(10_000), .GAP_CYCLES(1_000), .LOAD_AT(2)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .note(note),
    .beat(beat), .speaker(speaker), .cur_note(cur_note), .sounding(sounding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // steps until the selected output (0 speaker, 1 beat, 2 sounding) equals val; -1 on timeout
  task automatic wait_for(input int which, input logic val, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step(1);
      n++;
      if ((which == 0 ? speaker : which == 1 ? beat : sounding) === val) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    int beats;
    logic acc;
    #1 reset = 1'b1;
    #2;
    check("rst_beat", beat, 0);
    check("rst_speaker", speaker, 0);
    check("rst_sounding", sounding, 0);
    check("rst_cur_note", cur_note, 0);
    step(2);
    reset = 1'b0;
    state = splay;
    note = 5'd13;
    step(1);
    check("play_cnt0_note", cur_note, 0);
    check("play_cnt0_beat", beat, 0);
    step(2);
    check("pre_load_note", cur_note, 0);
    step(1);
    check("load13", cur_note, 13);
    check("load13_sounding", sounding, 1);
    check("load13_speaker", speaker, 0);
    wait_for(0, 1'b1, 5000, n);
    check("rise13", n, 1136);
    wait_for(0, 1'b0, 5000, n);
    check("half13", n, 1136);
    step(8999 - 2275);
    check("win_last_sounding", sounding, 1);
    check("win_last_speaker", speaker, 1);
    step(1);
    check("gap_sounding", sounding, 0);
    check("gap_speaker", speaker, 0);
    wait_for(1, 1'b1, 20000, n);
    check("first_beat", n, 999);
    note = 5'd15;
    step(1);
    check("beat_width", beat, 0);
    step(3);
    check("load15", cur_note, 15);
    wait_for(0, 1'b1, 5000, n);
    check("rise15", n, 956);
    step(8040);
    check("spk15_end", speaker, 1);
    step(1);
    check("gap15_sounding", sounding, 0);
    wait_for(2, 1'b1, 5000, n);
    check("gap_run", n, 1003);
    check("reload15", cur_note, 15);
    step(4996);
    check("pre_pause_speaker", speaker, 1);
    state = spause;
    step(1);
    check("pause_speaker", speaker, 0);
    check("pause_sounding", sounding, 0);
    acc = 1'b0;
    repeat (3000) begin
      step(1);
      acc = acc | speaker | beat | sounding;
    end
    check("pause_quiet", acc, 0);
    check("pause_note", cur_note, 15);
    state = splay;
    step(1);
    check("resume_phase", speaker, 1);
    wait_for(0, 1'b0, 2000, n);
    check("resume_fall", n, 739);
    wait_for(1, 1'b1, 20000, n);
    check("resume_beat", n, 4260);
    step(101);
    check("pre_stop_sounding", sounding, 1);
    state = sstop;
    step(1);
    check("stop_speaker", speaker, 0);
    check("stop_sounding", sounding, 0);
    step(1);
    check("stop_clear_note", cur_note, 0);
    note = 5'd13;
    state = splay;
    step(1);
    check("restart_cnt0_note", cur_note, 0);
    step(2);
    check("restart_preload", cur_note, 0);
    step(1);
    check("restart_load", cur_note, 13);
    wait_for(1, 1'b1, 20000, n);
    check("restart_beat", n, 9996);
    note = 5'd0;
    acc = 1'b0;
    beats = 0;
    repeat (10000) begin
      step(1);
      acc = acc | speaker | sounding;
      beats += int'(beat);
    end
    check("rest0_quiet", acc, 0);
    check("rest0_beats", beats, 1);
    check("rest0_note", cur_note, 0);
    note = 5'd25;
    acc = 1'b0;
    beats = 0;
    repeat (10000) begin
      step(1);
      acc = acc | speaker | sounding;
      beats += int'(beat);
    end
    check("note25_quiet", acc, 0);
    check("note25_beats", beats, 1);
    check("note25_latched0", cur_note, 0);
    note = 5'd13;
    wait_for(0, 1'b1, 20000, n);
    check("pre_reset_rise", n, 1140);
    #2 reset = 1'b1;
    #1;
    check("arst_speaker", speaker, 0);
    check("arst_sounding", sounding, 0);
    check("arst_cur_note", cur_note, 0);
    check("arst_beat", beat, 0);
    state = sstop;
    step(2);
    reset = 1'b0;
    step(1);
    check("post_reset_note", cur_note, 0);
    check("post_reset_speaker", speaker, 0);
    state = splay;
    step(1);
    step(9998);
    state = spause;
    step(1);
    check("pause_last_beat", beat, 0);
    step(5);
    check("pause_last_hold", beat, 0);
    state = splay;
    step(1);
    check("resume_last_beat", beat, 1);
    step(1);
    check("resume_last_after", beat, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
